score_digit_collector: RTL and testbench

//   Receive end of the multiplexed score-digit link. The transmitter drives one 4-bit
//   BCD digit per clock and flips a phase bit each clock. This block re-pairs ones/tens

---
 rtl/score_digit_collector.sv | 117 +++++++++++
 tb/tb_score_digit_collector.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/score_digit_collector.sv
// Receive end of the multiplexed score-digit link: re-pairs ones/tens digits into frames, debounces them and publishes a score.
// Optional feature macro: SCORE_BIN_EN adds the registered binary score output score_bin.
module score_digit_collector #(
  parameter int unsigned HOLD_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       phase_in,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic       score_valid,
  output logic       update_pulse,
  output logic       error_pulse
`ifdef SCORE_BIN_EN
  ,
  output logic [6:0] score_bin
`endif
);

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    ONES = 1'b1
  } state_t;

  localparam logic [3:0] HOLD = 4'(HOLD_FRAMES);

  state_t     state_r;
  logic [3:0] ones_r;
  logic [3:0] cand_ones_r;
  logic [3:0] cand_tens_r;
  logic [3:0] count_r;
  logic       pend_r;

  logic       frame_done_s;
  logic       frame_bad_s;
  logic       frame_same_s;
  logic [3:0] count_next_s;
  logic       publish_s;

  // Frame completion check, debounce count and publish decision for the current cycle
  always_comb begin
    frame_done_s = (state_r == ONES) && !phase_in;
    frame_bad_s  = (ones_r > 4'd9) || (digit_in > 4'd9);
    frame_same_s = (ones_r == cand_ones_r) && (digit_in == cand_tens_r);
    if (frame_same_s) begin
      count_next_s = (count_r >= HOLD) ? HOLD : count_r + 4'd1;
    end else begin
      count_next_s = 4'd1;
    end
    // The published score is stable here: a publish lands before the next frame can complete.
    publish_s = frame_done_s && !frame_bad_s && (count_next_s == HOLD) &&
                (!score_valid || (ones_r != score_ones) || (digit_in != score_tens));
  end

  // Link FSM, candidate/debounce state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= SYNC;
      ones_r       <= 4'd0;
      cand_ones_r  <= 4'd0;
      cand_tens_r  <= 4'd0;
      count_r      <= 4'd0;
      pend_r       <= 1'b0;
      score_ones   <= 4'd0;
      score_tens   <= 4'd0;
      score_valid  <= 1'b0;
      update_pulse <= 1'b0;
      error_pulse  <= 1'b0;
`ifdef SCORE_BIN_EN
      score_bin    <= 7'd0;
`endif
    end else begin
      error_pulse  <= 1'b0;
      update_pulse <= 1'b0;
      pend_r       <= publish_s;
      if (pend_r) begin
        score_ones   <= cand_ones_r;
        score_tens   <= cand_tens_r;
        score_valid  <= 1'b1;
        update_pulse <= 1'b1;
`ifdef SCORE_BIN_EN
        score_bin    <= ({3'b000, cand_tens_r} << 3) + ({3'b000, cand_tens_r} << 1) +
                        {3'b000, cand_ones_r};
`endif
      end
      case (state_r)
        SYNC: begin
          if (phase_in) begin
            ones_r  <= digit_in;
            state_r <= ONES;
          end else begin
            state_r <= SYNC;
          end
        end
        ONES: begin
          if (phase_in) begin
            error_pulse <= 1'b1;
            ones_r      <= digit_in;
          end else begin
            state_r <= SYNC;
            if (frame_bad_s) begin
              error_pulse <= 1'b1;
              count_r     <= 4'd0;
            end else begin
              cand_ones_r <= ones_r;
              cand_tens_r <= digit_in;
              count_r     <= count_next_s;
            end
          end
        end
        default: state_r <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_score_digit_collector.sv
// Directed bench for score_digit_collector with HOLD_FRAMES=2; score_bin is checked when SCORE_BIN_EN is defined.
module tb_score_digit_collector;

  logic       clk;
  logic       reset;
  logic [3:0] digit_in;
  logic       phase_in;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic       score_valid;
  logic       update_pulse;
  logic       error_pulse;
`ifdef SCORE_BIN_EN
  logic [6:0] score_bin;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  score_digit_collector #(.HOLD_FRAMES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .digit_in     (digit_in),
    .phase_in     (phase_in),
    .score_ones   (score_ones),
    .score_tens   (score_tens),
    .score_valid  (score_valid),
    .update_pulse (update_pulse),
    .error_pulse  (error_pulse)
`ifdef SCORE_BIN_EN
    ,
    .score_bin    (score_bin)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one (phase,digit) pair, let one rising edge sample it, then check both pulses.
  task automatic step(input string tag, input logic ph, input logic [3:0] dg,
                      input logic exp_err, input logic exp_upd);
    phase_in = ph;
    digit_in = dg;
    @(posedge clk);
    #1;
    chk({tag, ".err"}, {7'd0, error_pulse}, {7'd0, exp_err});
    chk({tag, ".upd"}, {7'd0, update_pulse}, {7'd0, exp_upd});
  endtask

  task automatic chk_score(input string tag, input logic [3:0] t, input logic [3:0] o,
                           input logic v, input logic [6:0] b);
    chk({tag, ".tens"}, {4'd0, score_tens}, {4'd0, t});
    chk({tag, ".ones"}, {4'd0, score_ones}, {4'd0, o});
    chk({tag, ".valid"}, {7'd0, score_valid}, {7'd0, v});
`ifdef SCORE_BIN_EN
    chk({tag, ".bin"}, {1'b0, score_bin}, {1'b0, b});
`else
    if (b > 7'd99) $error("FAIL %s.bin_ref observed=%0d expected<=99", tag, b);
`endif
  endtask

  initial begin
    reset    = 1'b1;
    phase_in = 1'b0;
    digit_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_score("rst", 4'd0, 4'd0, 1'b0, 7'd0);
    chk("rst.upd", {7'd0, update_pulse}, 8'd0);
    chk("rst.err", {7'd0, error_pulse}, 8'd0);
    reset = 1'b0;

    // 1: two identical frames publish 47, pulse lands the cycle after the second completion
    step("s1.a", 1'b1, 4'd7, 1'b0, 1'b0);
    step("s1.b", 1'b0, 4'd4, 1'b0, 1'b0);
    step("s1.c", 1'b1, 4'd7, 1'b0, 1'b0);
    step("s1.d", 1'b0, 4'd4, 1'b0, 1'b0);
    chk_score("s1.pre", 4'd0, 4'd0, 1'b0, 7'd0);
    step("s1.e", 1'b0, 4'd0, 1'b0, 1'b1);
    chk_score("s1", 4'd4, 4'd7, 1'b1, 7'd47);
    step("s1.f", 1'b0, 4'd0, 1'b0, 1'b0);

    // 2: steady 47, one glitch frame 48, steady 47: nothing republished
    step("s2.a", 1'b1, 4'd7, 1'b0, 1'b0);
    step("s2.b", 1'b0, 4'd4, 1'b0, 1'b0);
    step("s2.c", 1'b1, 4'd8, 1'b0, 1'b0);
    step("s2.d", 1'b0, 4'd4, 1'b0, 1'b0);
    step("s2.e", 1'b1, 4'd7, 1'b0, 1'b0);
    step("s2.f", 1'b0, 4'd4, 1'b0, 1'b0);
    step("s2.g", 1'b1, 4'd7, 1'b0, 1'b0);
    step("s2.h", 1'b0, 4'd4, 1'b0, 1'b0);
    step("s2.i", 1'b0, 4'd0, 1'b0, 1'b0);
    chk_score("s2", 4'd4, 4'd7, 1'b1, 7'd47);

    // 3: repeated phase drops the 3, frames resolve to 25
    step("s3.a", 1'b1, 4'd3, 1'b0, 1'b0);
    step("s3.b", 1'b1, 4'd5, 1'b1, 1'b0);
    step("s3.c", 1'b0, 4'd2, 1'b0, 1'b0);
    step("s3.d", 1'b1, 4'd3, 1'b0, 1'b0);
    step("s3.e", 1'b1, 4'd5, 1'b1, 1'b0);
    step("s3.f", 1'b0, 4'd2, 1'b0, 1'b0);
    step("s3.g", 1'b0, 4'd0, 1'b0, 1'b1);
    chk_score("s3", 4'd2, 4'd5, 1'b1, 7'd25);

    // 4: a non-BCD frame errors and clears the count, so 36 needs two more good frames
    step("s4.a", 1'b1, 4'd6, 1'b0, 1'b0);
    step("s4.b", 1'b0, 4'd3, 1'b0, 1'b0);
    step("s4.c", 1'b1, 4'hA, 1'b0, 1'b0);
    step("s4.d", 1'b0, 4'd1, 1'b1, 1'b0);
    step("s4.e", 1'b1, 4'd6, 1'b0, 1'b0);
    step("s4.f", 1'b0, 4'd3, 1'b0, 1'b0);
    step("s4.g", 1'b0, 4'd0, 1'b0, 1'b0);
    chk_score("s4.hold", 4'd2, 4'd5, 1'b1, 7'd25);
    step("s4.h", 1'b1, 4'd6, 1'b0, 1'b0);
    step("s4.i", 1'b0, 4'd3, 1'b0, 1'b0);
    step("s4.j", 1'b0, 4'd0, 1'b0, 1'b1);
    chk_score("s4", 4'd3, 4'd6, 1'b1, 7'd36);

    // 5: reset mid-frame, then the stray tens digit is ignored; 99 publishes from invalid state
    step("s5.a", 1'b1, 4'd9, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    chk_score("s5.rst", 4'd0, 4'd0, 1'b0, 7'd0);
    reset = 1'b0;
    step("s5.b", 1'b0, 4'd9, 1'b0, 1'b0);
    step("s5.c", 1'b1, 4'd9, 1'b0, 1'b0);
    step("s5.d", 1'b0, 4'd9, 1'b0, 1'b0);
    step("s5.e", 1'b1, 4'd9, 1'b0, 1'b0);
    step("s5.f", 1'b0, 4'd9, 1'b0, 1'b0);
    chk_score("s5.pre", 4'd0, 4'd0, 1'b0, 7'd0);
    step("s5.g", 1'b0, 4'd0, 1'b0, 1'b1);
    chk_score("s5", 4'd9, 4'd9, 1'b1, 7'd99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
